// File: rtl/mux_5x1_pkg.sv
// Shared constants for the 5:1 lane mux.
package mux_5x1_pkg;

    localparam int unsigned NUM_IN  = 5;
    localparam int unsigned SEL_W   = 3;
    localparam int unsigned MAX_SEL = 4;

endpackage : mux_5x1_pkg

// File: rtl/mux_5x1_if.sv
// Lane data, select and result bundle for the 5:1 mux.
interface mux_5x1_if
    import mux_5x1_pkg::*;
#(
    parameter int unsigned WIDTH = 1
);

    logic [NUM_IN*WIDTH-1:0] i;
    logic [SEL_W-1:0]        s;
    logic [WIDTH-1:0]        y;
    logic [WIDTH-1:0]        y_q;
    logic                    sel_err;
    logic                    sel_err_q;

    // Source of lanes/select; observes both combinational and registered results.
    modport master (
        output i, s,
        input  y, y_q, sel_err, sel_err_q
    );

    // The mux itself.
    modport slave (
        input  i, s,
        output y, y_q, sel_err, sel_err_q
    );

endinterface : mux_5x1_if

// File: rtl/mux_2x1.sv
// WIDTH-wide 2:1 mux leaf used to build the lane-select tree.
module mux_2x1 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);

    // sel=0 passes a, sel=1 passes b; a plain ternary keeps X on sel visible.
    assign y = sel ? b : a;

endmodule : mux_2x1

// File: rtl/mux_5x1.sv
// 5:1 lane mux built as a 2:1 tree, with combinational and registered outputs.
module mux_5x1
    import mux_5x1_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    mux_5x1_if.slave  bus
);

    localparam logic [WIDTH-1:0] ZERO = '0;

    logic [WIDTH-1:0] lane [NUM_IN];
    logic [WIDTH-1:0] l1_lo;
    logic [WIDTH-1:0] l1_hi;
    logic [WIDTH-1:0] l2;
    logic [WIDTH-1:0] l3;
    logic [WIDTH-1:0] y_d;
    logic             sel_err_d;
    logic [WIDTH-1:0] y_q;
    logic             sel_err_q;

    // Split the packed input into individual lanes.
    for (genvar k = 0; k < NUM_IN; k++) begin : g_lane
        assign lane[k] = bus.i[k*WIDTH +: WIDTH];
    end

    // Select values 5..7 have no lane behind them.
    assign sel_err_d = (bus.s > SEL_W'(MAX_SEL));

    // Level 1: s[0] picks within lanes 0/1 and within lanes 2/3.
    mux_2x1 #(.WIDTH(WIDTH)) u_l1_lo (.a(lane[0]), .b(lane[1]), .sel(bus.s[0]), .y(l1_lo));
    mux_2x1 #(.WIDTH(WIDTH)) u_l1_hi (.a(lane[2]), .b(lane[3]), .sel(bus.s[0]), .y(l1_hi));

    // Level 2: s[1] picks between the two level-1 pairs.
    mux_2x1 #(.WIDTH(WIDTH)) u_l2 (.a(l1_lo), .b(l1_hi), .sel(bus.s[1]), .y(l2));

    // Level 3: s[2] picks between lanes 0..3 and lane 4.
    mux_2x1 #(.WIDTH(WIDTH)) u_l3 (.a(l2), .b(lane[4]), .sel(bus.s[2]), .y(l3));

    // Out-of-range selects force zero so lane 4 cannot leak through on s=5..7.
    mux_2x1 #(.WIDTH(WIDTH)) u_zero (.a(l3), .b(ZERO), .sel(sel_err_d), .y(y_d));

    assign bus.y       = y_d;
    assign bus.sel_err = sel_err_d;

    // One-cycle registered copies, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q       <= '0;
            sel_err_q <= 1'b0;
        end else begin
            y_q       <= y_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign bus.y_q       = y_q;
    assign bus.sel_err_q = sel_err_q;

endmodule : mux_5x1

// File: tb/tb_mux_5x1.sv
// Bench for mux_5x1 at WIDTH=1 and WIDTH=8: vector tables, hand sequences, exhaustive sweep.
module tb_mux_5x1;

    logic clk;
    logic rst_n;

    mux_5x1_if #(.WIDTH(1)) if1 ();
    mux_5x1_if #(.WIDTH(8)) if8 ();

    mux_5x1 #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    mux_5x1 #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] i;
        logic [2:0] s;
        logic       y;
        logic       err;
    } vec1_t;

    typedef struct {
        logic [2:0] s;
        logic [7:0] y;
        logic       err;
    } vec8_t;

    typedef struct {
        logic       y1;
        logic       e1;
        logic [7:0] y8;
        logic       e8;
    } exp_t;

    exp_t sb_q [$];
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam logic [39:0] LANES8 = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};

    function automatic logic model1(input logic [4:0] iv, input logic [2:0] sv);
        if (sv > 3'd4) return 1'b0;
        return iv[sv];
    endfunction

    function automatic logic [7:0] model8(input logic [39:0] iv, input logic [2:0] sv);
        if (sv > 3'd4) return 8'h00;
        return iv[int'(sv)*8 +: 8];
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t i1=%b s1=%0d s8=%0d)",
                     name, act, exp, $time, if1.i, if1.s, if8.s);
        end
    endtask

    // Check combinational outputs now, queue expectations, check registered outputs after the edge.
    task automatic step();
        exp_t e;
        exp_t got;
        #1;
        e.y1 = model1(if1.i, if1.s);
        e.e1 = (if1.s > 3'd4);
        e.y8 = model8(if8.i, if8.s);
        e.e8 = (if8.s > 3'd4);
        chk("y1",       8'(if1.y),       8'(e.y1));
        chk("sel_err1", 8'(if1.sel_err), 8'(e.e1));
        chk("y8",       if8.y,           e.y8);
        chk("sel_err8", 8'(if8.sel_err), 8'(e.e8));
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 8'd0, 8'd1);
        end else begin
            got = sb_q.pop_front();
            chk("y_q1",       8'(if1.y_q),       8'(got.y1));
            chk("sel_err_q1", 8'(if1.sel_err_q), 8'(got.e1));
            chk("y_q8",       if8.y_q,           got.y8);
            chk("sel_err_q8", 8'(if8.sel_err_q), 8'(got.e8));
        end
    endtask

    // Mid-cycle reset pulse: registers clear at once, combinational outputs untouched.
    task automatic reset_pulse(input logic exp_y1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_y_q1",       8'(if1.y_q),       8'd0);
        chk("rst_sel_err_q1", 8'(if1.sel_err_q), 8'd0);
        chk("rst_y_q8",       if8.y_q,           8'd0);
        chk("rst_y1_live",    8'(if1.y),         8'(exp_y1));
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_y_q1",       8'(if1.y_q),       8'(model1(if1.i, if1.s)));
        chk("post_rst_sel_err_q1", 8'(if1.sel_err_q), 8'(if1.s > 3'd4));
    endtask

    vec1_t vt1 [8];
    vec8_t vt8 [6];

    initial begin
        vt1[0] = '{5'b10101, 3'd0, 1'b1, 1'b0};
        vt1[1] = '{5'b10101, 3'd1, 1'b0, 1'b0};
        vt1[2] = '{5'b10101, 3'd2, 1'b1, 1'b0};
        vt1[3] = '{5'b10101, 3'd3, 1'b0, 1'b0};
        vt1[4] = '{5'b10101, 3'd4, 1'b1, 1'b0};
        vt1[5] = '{5'b10101, 3'd5, 1'b0, 1'b1};
        vt1[6] = '{5'b10101, 3'd6, 1'b0, 1'b1};
        vt1[7] = '{5'b10101, 3'd7, 1'b0, 1'b1};

        vt8[0] = '{3'd0, 8'h11, 1'b0};
        vt8[1] = '{3'd1, 8'h22, 1'b0};
        vt8[2] = '{3'd2, 8'h33, 1'b0};
        vt8[3] = '{3'd3, 8'h44, 1'b0};
        vt8[4] = '{3'd4, 8'h55, 1'b0};
        vt8[5] = '{3'd6, 8'h00, 1'b1};

        // Reset state, with inputs that would otherwise produce nonzero results.
        rst_n  = 1'b0;
        if1.i  = 5'b10101;
        if1.s  = 3'd0;
        if8.i  = LANES8;
        if8.s  = 3'd0;
        #8;
        chk("init_y_q1",       8'(if1.y_q),       8'd0);
        chk("init_sel_err_q1", 8'(if1.sel_err_q), 8'd0);
        chk("init_y_q8",       if8.y_q,           8'd0);
        chk("init_y1_in_rst",  8'(if1.y),         8'd1);
        chk("init_y8_in_rst",  if8.y,             8'h11);
        @(negedge clk);
        rst_n = 1'b1;

        // WIDTH=1 table.
        foreach (vt1[k]) begin
            @(negedge clk);
            if1.i = vt1[k].i;
            if1.s = vt1[k].s;
            #1;
            chk("tbl1_y",   8'(if1.y),       8'(vt1[k].y));
            chk("tbl1_err", 8'(if1.sel_err), 8'(vt1[k].err));
            step();
        end

        // WIDTH=8 table.
        foreach (vt8[k]) begin
            @(negedge clk);
            if8.s = vt8[k].s;
            #1;
            chk("tbl8_y",   if8.y,           vt8[k].y);
            chk("tbl8_err", 8'(if8.sel_err), 8'(vt8[k].err));
            step();
        end

        // Lane 3 selected, then an out-of-range select.
        @(negedge clk);
        if1.i = 5'b01010;
        if1.s = 3'd3;
        #1;
        chk("seq_y_lane3", 8'(if1.y), 8'd1);
        step();
        chk("seq_y_q_lane3", 8'(if1.y_q), 8'd1);
        @(negedge clk);
        if1.s = 3'd7;
        #1;
        chk("seq_y_s7", 8'(if1.y), 8'd0);
        step();
        chk("seq_y_q_s7",       8'(if1.y_q),       8'd0);
        chk("seq_sel_err_q_s7", 8'(if1.sel_err_q), 8'd1);

        // Reset while sel_err_q is set (s=7 still applied).
        reset_pulse(1'b0);

        // Reset while y_q = 1.
        @(negedge clk);
        if1.i = 5'b10101;
        if1.s = 3'd0;
        step();
        chk("pre_rst_y_q1", 8'(if1.y_q), 8'd1);
        reset_pulse(1'b1);

        // Exhaustive sweep at WIDTH=1; WIDTH=8 select follows along.
        for (int iv = 0; iv < 32; iv++) begin
            for (int sv = 0; sv < 8; sv++) begin
                @(negedge clk);
                if1.i = 5'(iv);
                if1.s = 3'(sv);
                if8.s = 3'(7 - sv);
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_mux_5x1
